// File: rtl/plot_pkg.sv
// Shared definitions for the plot sequencer: width helpers and FSM state encoding.
package plot_pkg;

  localparam int STATE_W = 4;

  function automatic int x_width(input int hor);
    return $clog2(hor);
  endfunction

  function automatic int y_width(input int ver);
    return $clog2(ver);
  endfunction

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 4'd0,
    ST_AXES      = 4'd1,
    ST_AXES_WAIT = 4'd2,
    ST_SEL       = 4'd3,
    ST_EVAL      = 4'd4,
    ST_EVAL_WAIT = 4'd5,
    ST_PLOT      = 4'd6,
    ST_LINE      = 4'd7,
    ST_LINE_WAIT = 4'd8,
    ST_STEP      = 4'd9
  } state_e;

endpackage

// File: rtl/plot_sequencer_if.sv
// Evaluator request/response and line_drawer segment bus seen by the plot sequencer.
interface plot_if #(
  parameter int X_WIDTH  = 10,
  parameter int Y_WIDTH  = 9,
  parameter int CH_WIDTH = 2
);
  logic                eval_start;
  logic                eval_ready;
  logic [CH_WIDTH-1:0] eval_channel;
  logic [X_WIDTH-1:0]  eval_x;
  logic [Y_WIDTH-1:0]  eval_y;
  logic                eval_y_valid;
  logic [X_WIDTH-1:0]  x1;
  logic [Y_WIDTH-1:0]  y1;
  logic [X_WIDTH-1:0]  x2;
  logic [Y_WIDTH-1:0]  y2;
  logic                line_start;
  logic                line_ready;

  modport master (
    output eval_start, eval_channel, eval_x, x1, y1, x2, y2, line_start,
    input  eval_ready, eval_y, eval_y_valid, line_ready
  );

  modport slave (
    input  eval_start, eval_channel, eval_x, x1, y1, x2, y2, line_start,
    output eval_ready, eval_y, eval_y_valid, line_ready
  );
endinterface

// File: rtl/plot_channel_picker.sv
// Priority encoder: lowest enabled channel at or above from_i, plus a none-left flag.
module plot_channel_picker #(
  parameter int N_CHANNELS = 4,
  parameter int CH_WIDTH   = 2
) (
  input  logic [N_CHANNELS-1:0] mask_i,
  input  logic [CH_WIDTH:0]     from_i,
  output logic [CH_WIDTH-1:0]   pick_o,
  output logic                  none_left_o
);
  // Scan downwards so the last hit, i.e. the lowest index, wins.
  always_comb begin
    pick_o      = '0;
    none_left_o = 1'b1;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(from_i))) begin
        pick_o      = CH_WIDTH'(i);
        none_left_o = 1'b0;
      end
    end
  end
endmodule

// File: rtl/plot_sequencer.sv
// Plot controller: sweeps x per enabled channel, asks the evaluator for y, emits segments.
// Optional PLOT_SEQUENCER_AXES_EN draws the two screen axes before the first channel.
module plot_sequencer
  import plot_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int N_CHANNELS        = 4,
  parameter int X_STEP            = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  input  logic [N_CHANNELS-1:0] channel_mask,
  plot_if.master                bus
);
  localparam int X_WIDTH  = x_width(HOR_ACTIVE_PIXELS);
  localparam int Y_WIDTH  = y_width(VER_ACTIVE_PIXELS);
  localparam int CH_WIDTH = ch_width(N_CHANNELS);

  // x counter carries one spare bit so x + X_STEP never wraps before clamping.
  localparam logic [X_WIDTH:0] X_LAST = (X_WIDTH+1)'(HOR_ACTIVE_PIXELS - 1);
  localparam logic [X_WIDTH:0] X_INC  = (X_WIDTH+1)'(X_STEP);

  state_e                state_q, state_d;
  logic [X_WIDTH:0]      x_q, x_d;
  logic [CH_WIDTH-1:0]   ch_q, ch_d;
  logic [CH_WIDTH:0]     sel_q, sel_d;
  logic [N_CHANNELS-1:0] mask_q, mask_d;
  logic [Y_WIDTH-1:0]    y_q, y_d;
  logic                  yv_q, yv_d;
  logic                  pen_q, pen_d;
  logic [X_WIDTH-1:0]    x1_q, x1_d, x2_q, x2_d;
  logic [Y_WIDTH-1:0]    y1_q, y1_d, y2_q, y2_d;
  logic [X_WIDTH:0]      x_sum;
  logic [CH_WIDTH-1:0]   pick;
  logic                  none_left;

`ifdef PLOT_SEQUENCER_AXES_EN
  localparam logic [X_WIDTH-1:0] X_MID = X_WIDTH'(HOR_ACTIVE_PIXELS / 2);
  localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(HOR_ACTIVE_PIXELS - 1);
  localparam logic [Y_WIDTH-1:0] Y_MID = Y_WIDTH'(VER_ACTIVE_PIXELS / 2);
  localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(VER_ACTIVE_PIXELS - 1);
  logic axis_q, axis_d;
`endif

  plot_channel_picker #(
    .N_CHANNELS (N_CHANNELS),
    .CH_WIDTH   (CH_WIDTH)
  ) u_picker (
    .mask_i      (mask_q),
    .from_i      (sel_q),
    .pick_o      (pick),
    .none_left_o (none_left)
  );

  assign x_sum = x_q + X_INC;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ch_d    = ch_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    y_d     = y_q;
    yv_d    = yv_q;
    pen_d   = pen_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x2_d    = x2_q;
    y2_d    = y2_q;
`ifdef PLOT_SEQUENCER_AXES_EN
    axis_d  = axis_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = channel_mask;
          sel_d   = '0;
          ch_d    = '0;
          x_d     = '0;
          pen_d   = 1'b0;
`ifdef PLOT_SEQUENCER_AXES_EN
          x1_d    = '0;
          y1_d    = Y_MID;
          x2_d    = X_MAX;
          y2_d    = Y_MID;
          axis_d  = 1'b0;
          state_d = ST_AXES;
`else
          state_d = ST_SEL;
`endif
        end
      end
`ifdef PLOT_SEQUENCER_AXES_EN
      ST_AXES:      if (bus.line_ready) state_d = ST_AXES_WAIT;
      ST_AXES_WAIT: begin
        if (bus.line_ready) begin
          if (!axis_q) begin
            x1_d    = X_MID;
            y1_d    = '0;
            x2_d    = X_MID;
            y2_d    = Y_MAX;
            axis_d  = 1'b1;
            state_d = ST_AXES;
          end else begin
            state_d = ST_SEL;
          end
        end
      end
`endif
      ST_SEL: begin
        if (none_left) begin
          state_d = ST_IDLE;
        end else begin
          ch_d    = pick;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL:      if (bus.eval_ready) state_d = ST_EVAL_WAIT;
      ST_EVAL_WAIT: begin
        if (bus.eval_ready) begin
          y_d     = bus.eval_y;
          yv_d    = bus.eval_y_valid;
          state_d = ST_PLOT;
        end
      end
      ST_PLOT: begin
        x1_d    = x2_q;
        y1_d    = y2_q;
        x2_d    = x_q[X_WIDTH-1:0];
        y2_d    = y_q;
        pen_d   = yv_q;
        // pen_q is low for a channel's first point and after any invalid point
        state_d = (pen_q && yv_q) ? ST_LINE : ST_STEP;
      end
      ST_LINE:      if (bus.line_ready) state_d = ST_LINE_WAIT;
      ST_LINE_WAIT: if (bus.line_ready) state_d = ST_STEP;
      ST_STEP: begin
        if (x_q == X_LAST) begin
          x_d     = '0;
          pen_d   = 1'b0;
          sel_d   = {1'b0, ch_q} + (CH_WIDTH+1)'(1);
          state_d = ST_SEL;
        end else begin
          x_d     = (x_sum > X_LAST) ? X_LAST : x_sum;
          state_d = ST_EVAL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      ch_q    <= '0;
      sel_q   <= '0;
      mask_q  <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      pen_q   <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
`ifdef PLOT_SEQUENCER_AXES_EN
      axis_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ch_q    <= ch_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      pen_q   <= pen_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
`ifdef PLOT_SEQUENCER_AXES_EN
      axis_q  <= axis_d;
`endif
    end
  end

  assign ready            = (state_q == ST_IDLE);
  assign bus.eval_start   = (state_q == ST_EVAL) && bus.eval_ready;
`ifdef PLOT_SEQUENCER_AXES_EN
  assign bus.line_start   = ((state_q == ST_LINE) || (state_q == ST_AXES)) && bus.line_ready;
`else
  assign bus.line_start   = (state_q == ST_LINE) && bus.line_ready;
`endif
  assign bus.eval_channel = ch_q;
  assign bus.eval_x       = x_q[X_WIDTH-1:0];
  assign bus.x1           = x1_q;
  assign bus.y1           = y1_q;
  assign bus.x2           = x2_q;
  assign bus.y2           = y2_q;

endmodule

// File: tb/tb_plot_sequencer.sv
// Scoreboard bench: dut_a (HOR=8, step 1) and dut_b (HOR=10, step 4), evaluator y = x + channel.
module tb_plot_sequencer;
  import plot_pkg::*;

  localparam int XWA = 3;
  localparam int XWB = 4;
  localparam int YW  = 4;
  localparam int CHW = 2;

  typedef struct { int ch; int x; } ev_t;
  typedef struct { int ch; int x1; int y1; int x2; int y2; } seg_t;

  logic clk = 1'b0;
  logic rst;
  logic start_a, ready_a, start_b, ready_b;
  logic [3:0] mask_a, mask_b;

  always #5 clk = ~clk;

  plot_if #(.X_WIDTH(XWA), .Y_WIDTH(YW), .CH_WIDTH(CHW)) bus_a();
  plot_if #(.X_WIDTH(XWB), .Y_WIDTH(YW), .CH_WIDTH(CHW)) bus_b();

  plot_sequencer #(.HOR_ACTIVE_PIXELS(8), .VER_ACTIVE_PIXELS(16), .N_CHANNELS(4), .X_STEP(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ready(ready_a), .channel_mask(mask_a), .bus(bus_a));
  plot_sequencer #(.HOR_ACTIVE_PIXELS(10), .VER_ACTIVE_PIXELS(16), .N_CHANNELS(4), .X_STEP(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ready(ready_b), .channel_mask(mask_b), .bus(bus_b));

  int   n_tests = 0;
  int   n_fail  = 0;
  ev_t  evq_a[$], evq_b[$];
  seg_t sgq_a[$], sgq_b[$];
  int   eval_dly = 0, line_dly = 0, inv_x = -1, inv_ch = -1;
  logic ev_prev_a = 1'b0, ln_prev_a = 1'b0, ev_prev_b = 1'b0;
  int   cap_x_a, cap_ch_a, cap_x_b;
  logic hold_a = 1'b0;
  seg_t held;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Evaluator / line_drawer models for dut_a: react one edge after the pulse, like a real peer.
  initial begin
    int ecnt, lcnt;
    ecnt = 0; lcnt = 0;
    bus_a.eval_ready = 1'b1; bus_a.eval_y = '0; bus_a.eval_y_valid = 1'b1; bus_a.line_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ecnt = 0; lcnt = 0; bus_a.eval_ready = 1'b1; bus_a.line_ready = 1'b1;
      end else begin
        if (ev_prev_a) begin
          bus_a.eval_y       = YW'(cap_x_a + cap_ch_a);
          bus_a.eval_y_valid = !(cap_x_a == inv_x && cap_ch_a == inv_ch);
          if (eval_dly > 0) begin bus_a.eval_ready = 1'b0; ecnt = eval_dly; end
        end else if (ecnt > 0) begin
          ecnt--;
          if (ecnt == 0) bus_a.eval_ready = 1'b1;
        end
        if (ln_prev_a) begin
          if (line_dly > 0) begin bus_a.line_ready = 1'b0; lcnt = line_dly; end
        end else if (lcnt > 0) begin
          lcnt--;
          if (lcnt == 0) bus_a.line_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    bus_b.eval_ready = 1'b1; bus_b.eval_y = '0; bus_b.eval_y_valid = 1'b1; bus_b.line_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ev_prev_b) bus_b.eval_y = YW'(cap_x_b);
    end
  end

  // Monitor dut_a
  always @(negedge clk) begin
    ev_t  e;
    seg_t s;
    if (rst) begin
      hold_a = 1'b0;
    end else begin
      if (bus_a.eval_start) begin
        check("a_eval_pulse_1cyc", int'(ev_prev_a), 0);
        cap_x_a  = int'(bus_a.eval_x);
        cap_ch_a = int'(bus_a.eval_channel);
        if (evq_a.size() == 0) check("a_eval_unexpected", 1, 0);
        else begin
          e = evq_a.pop_front();
          check("a_eval_ch", cap_ch_a, e.ch);
          check("a_eval_x", cap_x_a, e.x);
        end
      end
      if (hold_a) begin
        if (bus_a.line_ready) hold_a = 1'b0;
        else check("a_seg_stable",
                   int'({bus_a.x1 != XWA'(held.x1), bus_a.y1 != YW'(held.y1),
                         bus_a.x2 != XWA'(held.x2), bus_a.y2 != YW'(held.y2)}), 0);
      end
      if (bus_a.line_start) begin
        check("a_line_pulse_1cyc", int'(ln_prev_a), 0);
        held = '{int'(bus_a.eval_channel), int'(bus_a.x1), int'(bus_a.y1), int'(bus_a.x2), int'(bus_a.y2)};
        hold_a = 1'b1;
        if (sgq_a.size() == 0) check("a_seg_unexpected", 1, 0);
        else begin
          s = sgq_a.pop_front();
          check("a_seg_ch", held.ch, s.ch);
          check("a_seg_x1", held.x1, s.x1);
          check("a_seg_y1", held.y1, s.y1);
          check("a_seg_x2", held.x2, s.x2);
          check("a_seg_y2", held.y2, s.y2);
        end
      end
    end
    ev_prev_a = bus_a.eval_start;
    ln_prev_a = bus_a.line_start;
  end

  // Monitor dut_b
  always @(negedge clk) begin
    ev_t  e;
    seg_t s;
    if (!rst) begin
      if (bus_b.eval_start) begin
        cap_x_b = int'(bus_b.eval_x);
        if (evq_b.size() == 0) check("b_eval_unexpected", 1, 0);
        else begin
          e = evq_b.pop_front();
          check("b_eval_ch", int'(bus_b.eval_channel), e.ch);
          check("b_eval_x", cap_x_b, e.x);
        end
      end
      if (bus_b.line_start) begin
        if (sgq_b.size() == 0) check("b_seg_unexpected", 1, 0);
        else begin
          s = sgq_b.pop_front();
          check("b_seg_x1", int'(bus_b.x1), s.x1);
          check("b_seg_y1", int'(bus_b.y1), s.y1);
          check("b_seg_x2", int'(bus_b.x2), s.x2);
          check("b_seg_y2", int'(bus_b.y2), s.y2);
        end
      end
    end
    ev_prev_b = bus_b.eval_start;
  end

  // Full 0..7 sweep of one channel on dut_a, y = x + ch, no segment touching the invalid x.
  task automatic push_sweep_a(input int ch, input int bad_x);
    for (int x = 0; x < 8; x++) evq_a.push_back('{ch, x});
    for (int k = 0; k < 7; k++)
      if (k != bad_x && k + 1 != bad_x) sgq_a.push_back('{ch, k, k + ch, k + 1, k + 1 + ch});
  endtask

  // Start a frame; mask is scrambled right after acceptance to show it is not re-read.
  task automatic go_a(input logic [3:0] m, input int exp_cyc, input string nm);
    int n;
    @(negedge clk); mask_a = m; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0; mask_a = ~m;
    check({nm, "_busy"}, int'(ready_a), 0);
    n = 0;
    while (!ready_a && n < 3000) begin @(posedge clk); #1; n++; end
    check({nm, "_done"}, int'(ready_a), 1);
    if (exp_cyc >= 0) check({nm, "_cycles"}, n, exp_cyc);
    repeat (2) @(posedge clk);
    check({nm, "_evq_empty"}, evq_a.size(), 0);
    check({nm, "_segq_empty"}, sgq_a.size(), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mask_a = '0; mask_b = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_ready", int'(ready_a), 1);
    check("rst_eval_start", int'(bus_a.eval_start), 0);
    check("rst_line_start", int'(bus_a.line_start), 0);
    check("rst_x1", int'(bus_a.x1), 0);
    check("rst_y1", int'(bus_a.y1), 0);
    check("rst_x2", int'(bus_a.x2), 0);
    check("rst_y2", int'(bus_a.y2), 0);
    check("rst_eval_x", int'(bus_a.eval_x), 0);
    check("rst_eval_ch", int'(bus_a.eval_channel), 0);
    @(negedge clk); rst = 1'b0;

    // 1: single channel, step 1: SEL + 4 (first point) + 7*6 + SEL = 48 cycles
    push_sweep_a(0, -1);
    go_a(4'b0001, 48, "t1");

    // 3: invalid point at x=3 breaks the curve around it
    inv_x = 3; inv_ch = 0;
    push_sweep_a(0, 3);
    go_a(4'b0001, 44, "t3");
    inv_x = -1; inv_ch = -1;

    // 4: channels 1 and 3, pen lifted between them
    push_sweep_a(1, -1);
    push_sweep_a(3, -1);
    go_a(4'b1010, 95, "t4");

    // 5: slow peers
    eval_dly = 5; line_dly = 7;
    push_sweep_a(0, -1);
    go_a(4'b0001, -1, "t5");
    eval_dly = 0; line_dly = 0;

    // 2: dut_b, HOR=10, X_STEP=4 -> x 0,4,8,9 (last step clamped)
    evq_b.push_back('{0, 0}); evq_b.push_back('{0, 4});
    evq_b.push_back('{0, 8}); evq_b.push_back('{0, 9});
    sgq_b.push_back('{0, 0, 0, 4, 4});
    sgq_b.push_back('{0, 4, 4, 8, 8});
    sgq_b.push_back('{0, 8, 8, 9, 9});
    @(negedge clk); mask_b = 4'b0001; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    n = 0;
    while (!ready_b && n < 3000) begin @(posedge clk); #1; n++; end
    check("t2_done", int'(ready_b), 1);
    check("t2_cycles", n, 24);
    repeat (2) @(posedge clk);
    check("t2_evq_empty", evq_b.size(), 0);
    check("t2_segq_empty", sgq_b.size(), 0);

    // 6: reset mid-frame, then an empty-mask frame
    push_sweep_a(0, -1);
    @(negedge clk); mask_a = 4'b0001; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_ready", int'(ready_a), 1);
    check("t6_rst_eval_start", int'(bus_a.eval_start), 0);
    check("t6_rst_line_start", int'(bus_a.line_start), 0);
    check("t6_rst_x2", int'(bus_a.x2), 0);
    check("t6_rst_y2", int'(bus_a.y2), 0);
    check("t6_rst_eval_x", int'(bus_a.eval_x), 0);
    evq_a.delete(); sgq_a.delete();
    @(negedge clk); rst = 1'b0;
    go_a(4'b0000, 1, "t6_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
